// File: rtl/match_controller.sv
// Two-player match sequencer: collects one action per player per turn, commits both
// simultaneously, judges Player health and tracks round wins until a match winner emerges.
module match_controller #(
  parameter int TURN_CYCLES   = 16,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] a_act,
  input  logic [2:0] b_act,
  input  logic       a_vld,
  input  logic       b_vld,
  output logic       a_rdy,
  output logic       b_rdy,
  input  logic [1:0] a_hlt,
  input  logic [1:0] b_hlt,
  output logic       p_rst,
  output logic       a_en,
  output logic       b_en,
  output logic       sw,
  output logic [2:0] a_cmd,
  output logic [2:0] b_cmd,
  output logic [7:0] turn,
  output logic [1:0] a_wins,
  output logic [1:0] b_wins,
  output logic [1:0] winner
);

  localparam int         TW         = $clog2(TURN_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TURN_CYCLES - 1);
  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {
    IDLE, RSET, COLLECT, COMMIT, SETTLE, JUDGE, MATCH_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          a_got, b_got;
  logic [2:0]    a_lat, b_lat;
  logic          a_hs, b_hs;
  logic [2:0]    a_lat_nxt, b_lat_nxt;
  logic          a_round, b_round, match_won, restart;

  // Outputs are pure decodes of registered state, so reset clears them without a clock.
  assign p_rst = (state == IDLE) || (state == RSET);
  assign sw    = (state == COMMIT);
  assign a_en  = (state != COMMIT);
  assign b_en  = (state != COMMIT);
  assign a_rdy = (state == COLLECT) && !a_got;
  assign b_rdy = (state == COLLECT) && !b_got;

  always_comb begin
    a_hs      = (state == COLLECT) && !a_got && a_vld;
    b_hs      = (state == COLLECT) && !b_got && b_vld;
    a_lat_nxt = a_lat;
    b_lat_nxt = b_lat;
    // The unused code 111 is treated as "no action".
    if (a_hs) a_lat_nxt = (a_act == 3'b111) ? 3'b000 : a_act;
    if (b_hs) b_lat_nxt = (b_act == 3'b111) ? 3'b000 : b_act;

    a_round   = (state == JUDGE) && (b_hlt == 2'd0) && (a_hlt != 2'd0);
    b_round   = (state == JUDGE) && (a_hlt == 2'd0) && (b_hlt != 2'd0);
    match_won = (a_round && (a_wins + 2'd1 == WIN_TARGET)) ||
                (b_round && (b_wins + 2'd1 == WIN_TARGET));
    restart   = ((state == IDLE) || (state == MATCH_OVER)) && start;

    state_nxt = state;
    case (state)
      IDLE, MATCH_OVER: if (start) state_nxt = RSET;
      RSET:             state_nxt = COLLECT;
      COLLECT: begin
        if (((a_got || a_hs) && (b_got || b_hs)) || (timer == TIMER_LAST))
          state_nxt = COMMIT;
      end
      COMMIT:           state_nxt = SETTLE;
      SETTLE:           state_nxt = JUDGE;
      JUDGE: begin
        if ((a_hlt == 2'd0) || (b_hlt == 2'd0))
          state_nxt = match_won ? MATCH_OVER : RSET;
        else
          state_nxt = COLLECT;
      end
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      timer  <= '0;
      a_got  <= 1'b0;
      b_got  <= 1'b0;
      a_lat  <= 3'b000;
      b_lat  <= 3'b000;
      a_cmd  <= 3'b000;
      b_cmd  <= 3'b000;
      turn   <= 8'd0;
      a_wins <= 2'd0;
      b_wins <= 2'd0;
      winner <= 2'd0;
    end else begin
      state <= state_nxt;
      timer <= (state == COLLECT) ? timer + 1'b1 : '0;

      if ((state == COMMIT) || (state == RSET)) begin
        a_got <= 1'b0;
        b_got <= 1'b0;
        a_lat <= 3'b000;
        b_lat <= 3'b000;
      end else begin
        if (a_hs) a_got <= 1'b1;
        if (b_hs) b_got <= 1'b1;
        a_lat <= a_lat_nxt;
        b_lat <= b_lat_nxt;
      end

      // Load commands on the edge into COMMIT so a handshake in the exit cycle is included.
      if ((state == COLLECT) && (state_nxt == COMMIT)) begin
        a_cmd <= a_lat_nxt;
        b_cmd <= b_lat_nxt;
      end

      if (state_nxt == RSET)
        turn <= 8'd0;
      else if ((state == COMMIT) && (turn != 8'hFF))
        turn <= turn + 8'd1;

      if (restart) begin
        a_wins <= 2'd0;
        b_wins <= 2'd0;
        winner <= 2'd0;
      end else begin
        if (a_round) a_wins <= a_wins + 2'd1;
        if (b_round) b_wins <= b_wins + 2'd1;
        if (match_won) winner <= a_round ? 2'b01 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: a scoreboard queue holds expected commits,
// a forked monitor pops one entry per sw strobe; the main flow checks control timing.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] a_act, b_act;
  logic       a_vld, b_vld;
  logic       a_rdy, b_rdy;
  logic [1:0] a_hlt, b_hlt;
  logic       p_rst, a_en, b_en, sw;
  logic [2:0] a_cmd, b_cmd;
  logic [7:0] turn;
  logic [1:0] a_wins, b_wins, winner;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [7:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  always #5 clk = ~clk;

  match_controller #(.TURN_CYCLES(16), .ROUNDS_TO_WIN(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_act(a_act), .b_act(b_act), .a_vld(a_vld), .b_vld(b_vld),
    .a_rdy(a_rdy), .b_rdy(b_rdy), .a_hlt(a_hlt), .b_hlt(b_hlt),
    .p_rst(p_rst), .a_en(a_en), .b_en(b_en), .sw(sw),
    .a_cmd(a_cmd), .b_cmd(b_cmd), .turn(turn),
    .a_wins(a_wins), .b_wins(b_wins), .winner(winner)
  );

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic av, input logic [2:0] aa,
                                input logic bv, input logic [2:0] ba);
    a_vld = av; a_act = aa;
    b_vld = bv; b_act = ba;
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [2:0] b, input logic [7:0] t);
    exp_t e;
    e.a = a; e.b = b; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && sw) begin
        check_output("commit_en", 8'({a_en, b_en}), 8'd0);
        if (exp_q.size() == 0) begin
          check_output("unexpected_sw", 8'(sw), 8'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("a_cmd", 8'(a_cmd), 8'(e.a));
          check_output("b_cmd", 8'(b_cmd), 8'(e.b));
          check_output("turn_at_commit", turn, e.t);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b0; start = 1'b0;
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    a_hlt = 2'd3; b_hlt = 2'd3;
    #3;
    check_output("rst_p_rst", 8'(p_rst), 8'd1);
    check_output("rst_en", 8'({a_en, b_en}), 8'd3);
    check_output("rst_sw", 8'(sw), 8'd0);
    check_output("rst_rdy", 8'({a_rdy, b_rdy}), 8'd0);
    check_output("rst_turn", turn, 8'd0);
    check_output("rst_winner", 8'(winner), 8'd0);
    check_output("rst_cmd", 8'({a_cmd, b_cmd}), 8'd0);
    step(); step();
    @(negedge clk); rst = 1'b1;
    step();
    check_output("idle_p_rst", 8'(p_rst), 8'd1);

    // Normal turn: A 101, B 100 two cycles later.
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("rset_p_rst", 8'(p_rst), 8'd1);
    step();
    check_output("collect_rdy", 8'({a_rdy, b_rdy}), 8'd3);
    check_output("collect_p_rst", 8'(p_rst), 8'd0);
    push_exp(3'b101, 3'b100, 8'd0);
    apply_stimulus(1'b1, 3'b101, 1'b0, 3'b000);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    check_output("a_got_rdy", 8'({a_rdy, b_rdy}), 8'd1);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b1, 3'b100);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    check_output("commit_sw", 8'(sw), 8'd1);
    step();
    check_output("settle_turn", turn, 8'd1);
    check_output("settle_sw", 8'(sw), 8'd0);
    step();
    check_output("judge_rdy", 8'({a_rdy, b_rdy}), 8'd0);
    step();
    check_output("next_turn_rdy", 8'({a_rdy, b_rdy}), 8'd3);

    // Timeout: only A sends 001, COLLECT must last 16 cycles.
    cnt = 1;
    push_exp(3'b001, 3'b000, 8'd1);
    apply_stimulus(1'b1, 3'b001, 1'b0, 3'b000);
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
      if (sw) break;
      cnt++;
    end
    check_output("timeout_cycles", 8'(cnt), 8'd16);
    step(); step(); step();

    // Code 111 is committed as 000.
    push_exp(3'b000, 3'b010, 8'd2);
    apply_stimulus(1'b1, 3'b111, 1'b1, 3'b010);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    step(); step(); step();

    // Round 1 to A.
    push_exp(3'b010, 3'b011, 8'd3);
    apply_stimulus(1'b1, 3'b010, 1'b1, 3'b011);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    b_hlt = 2'd0; a_hlt = 2'd2;
    step(); step(); step();
    check_output("r1_p_rst", 8'(p_rst), 8'd1);
    check_output("r1_a_wins", 8'(a_wins), 8'd1);
    check_output("r1_b_wins", 8'(b_wins), 8'd0);
    check_output("r1_turn", turn, 8'd0);
    b_hlt = 2'd3; a_hlt = 2'd3;
    step();
    check_output("r1_p_rst_pulse", 8'(p_rst), 8'd0);
    check_output("r1_rdy", 8'({a_rdy, b_rdy}), 8'd3);

    // Round 2 to A: match over.
    push_exp(3'b001, 3'b001, 8'd0);
    apply_stimulus(1'b1, 3'b001, 1'b1, 3'b001);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    b_hlt = 2'd0; a_hlt = 2'd2;
    step(); step(); step();
    b_hlt = 2'd3; a_hlt = 2'd3;
    check_output("mo_a_wins", 8'(a_wins), 8'd2);
    check_output("mo_winner", 8'(winner), 8'd1);
    check_output("mo_p_rst", 8'(p_rst), 8'd0);
    apply_stimulus(1'b1, 3'b011, 1'b1, 3'b011);
    step(); step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    check_output("mo_rdy", 8'({a_rdy, b_rdy}), 8'd0);
    check_output("mo_en", 8'({a_en, b_en}), 8'd3);
    check_output("mo_winner_hold", 8'(winner), 8'd1);

    // Restart from MATCH_OVER.
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("rs_a_wins", 8'(a_wins), 8'd0);
    check_output("rs_winner", 8'(winner), 8'd0);
    check_output("rs_p_rst", 8'(p_rst), 8'd1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("start_ignored", 8'({p_rst, a_rdy, b_rdy}), 8'd3);

    // Draw: round replayed, no wins.
    push_exp(3'b011, 3'b100, 8'd0);
    apply_stimulus(1'b1, 3'b011, 1'b1, 3'b100);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    a_hlt = 2'd0; b_hlt = 2'd0;
    step(); step(); step();
    a_hlt = 2'd3; b_hlt = 2'd3;
    check_output("draw_p_rst", 8'(p_rst), 8'd1);
    check_output("draw_wins", 8'({a_wins, b_wins}), 8'd0);
    step();
    check_output("draw_collect", 8'({p_rst, a_rdy, b_rdy}), 8'd3);

    // Round to B.
    push_exp(3'b101, 3'b110, 8'd0);
    apply_stimulus(1'b1, 3'b101, 1'b1, 3'b110);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    a_hlt = 2'd0; b_hlt = 2'd1;
    step(); step(); step();
    a_hlt = 2'd3; b_hlt = 2'd3;
    check_output("bw_wins", 8'({a_wins, b_wins}), 8'd1);
    check_output("bw_winner", 8'(winner), 8'd0);
    step();

    // Asynchronous reset in the middle of COMMIT.
    push_exp(3'b001, 3'b010, 8'd0);
    apply_stimulus(1'b1, 3'b001, 1'b1, 3'b010);
    step();
    apply_stimulus(1'b0, 3'b000, 1'b0, 3'b000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("arst_sw", 8'(sw), 8'd0);
    check_output("arst_en", 8'({a_en, b_en}), 8'd3);
    check_output("arst_p_rst", 8'(p_rst), 8'd1);
    check_output("arst_wins", 8'({a_wins, b_wins}), 8'd0);
    check_output("arst_winner", 8'(winner), 8'd0);
    check_output("arst_cmd", 8'({a_cmd, b_cmd}), 8'd0);
    step();
    rst = 1'b1;
    step(); step();

    check_output("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
